inst_mem_prefetch: RTL and testbench

- Parametrised LC3 instruction memory with a built-in sequential prefetch engine.
- Holds a loadable word array and fetches ahead from a fetch PC into a first-word-fall-through (FWFT) FIFO, inserting WAIT_CYCLES wait states per access.
- Delivers {pc, instruction} pairs to the fetch stage over a valid/ready handshake.
- Branch/JMP redirects flush the FIFO and restart prefetch; the block replaces the single-cycle combinational instruction memory model.

---
 rtl/inst_mem_prefetch.sv | 147 ++++++++++++++
 tb/tb_inst_mem_prefetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_prefetch.sv
// LC3 instruction memory with a sequential prefetch engine that feeds a
// first-word-fall-through FIFO of {pc, instruction} pairs to the fetch stage.
//
// state  | meaning
// IDLE   | no access in flight; issues when enabled and the FIFO has room
// ACCESS | access to acc_pc in flight; wait_cnt counts remaining wait states
module inst_mem_prefetch #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                MEM_DEPTH   = 256,
  parameter int                FIFO_DEPTH  = 4,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] RESET_PC    = 16'h3000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          fetch_en,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_pc,
  output logic                          instr_valid,
  output logic [DATA_W-1:0]             instr_data,
  output logic [ADDR_W-1:0]             instr_pc,
  input  logic                          instr_ready,
  input  logic                          load_en,
  input  logic [ADDR_W-1:0]             load_addr,
  input  logic [DATA_W-1:0]             load_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [3:0]       WAIT_LOAD = 4'(WAIT_CYCLES);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]        state;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] acc_pc;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic issue;
  logic push;
  logic pop;

  // Array read is combinational off acc_pc, so a same-cycle load returns the old word.
  always_ff @(posedge clock) begin
    if (load_en) begin
      mem[load_addr[MEM_AW-1:0]] <= load_data;
    end
  end

  assign rd_word = mem[acc_pc[MEM_AW-1:0]];

  generate
    if (ADDR_W > MEM_AW) begin : g_addr_hi
      logic unused_load_addr_hi;
      assign unused_load_addr_hi = ^load_addr[ADDR_W-1:MEM_AW];
    end
  endgenerate

  assign issue = (state == IDLE) && fetch_en && !redirect_valid && (fifo_level < LVL_FULL);
  assign push  = (state == ACCESS) && (wait_cnt == '0) && !redirect_valid;
  assign pop   = instr_valid && instr_ready && !redirect_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      fetch_pc <= RESET_PC;
      acc_pc   <= '0;
    end else if (redirect_valid) begin
      state    <= IDLE;
      wait_cnt <= '0;
      fetch_pc <= redirect_pc;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state    <= ACCESS;
            wait_cnt <= WAIT_LOAD;
            acc_pc   <= fetch_pc;
          end
        end
        ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            state    <= IDLE;
            fetch_pc <= acc_pc + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (redirect_valid) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + LVL_W'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LVL_W'(1);
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the level is zero.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= rd_word;
      fifo_pc[wr_ptr]   <= acc_pc;
    end
  end

  assign instr_valid = (fifo_level != '0);
  assign instr_data  = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;
  assign busy        = (state == ACCESS);

endmodule

// File: tb/tb_inst_mem_prefetch.sv
// Bench for inst_mem_prefetch: directed timing scenarios plus a randomized
// run checked against an in-order {pc, word} scoreboard and a memory image.
module tb_inst_mem_prefetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        instr_ready = 1'b0;
  logic        load_en = 1'b0;
  logic [15:0] load_addr = '0;
  logic [15:0] load_data = '0;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic [2:0]  fifo_level;
  logic        busy;

  logic [15:0] mem_m [256];
  int          checks = 0;
  int          failures = 0;

  inst_mem_prefetch dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .fifo_level     (fifo_level),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [15:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
    mem_m[a[7:0]] = d;
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!instr_valid && cyc < 40);
    if (!instr_valid) check_val({tag, "_timeout"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic check_head(input string tag, input logic [15:0] pc);
    check_val({tag, "_pc"}, 32'(instr_pc), 32'(pc));
    check_val({tag, "_data"}, 32'(instr_data), 32'(mem_m[pc[7:0]]));
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check_val({tag, "_level"}, 32'(fifo_level), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_data"}, 32'(instr_data), 32'd0);
    check_val({tag, "_pc"}, 32'(instr_pc), 32'd0);
  endtask

  initial begin
    int          cyc;
    int          n;
    int          pops;
    logic [15:0] old_word;
    logic [15:0] exp_pc;
    logic [15:0] seq_words [4];

    seq_words[0] = 16'h1021;
    seq_words[1] = 16'h1262;
    seq_words[2] = 16'h14A3;
    seq_words[3] = 16'h16E4;

    // reset and idle
    repeat (3) tick();
    check_zero_outputs("in_reset");
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("idle_valid", 32'(instr_valid), 32'd0);
      check_val("idle_level", 32'(fifo_level), 32'd0);
      check_val("idle_busy", 32'(busy), 32'd0);
    end

    for (int i = 0; i < 256; i++) load_word(16'(i), 16'($urandom));
    for (int i = 0; i < 4; i++) load_word(16'(i), seq_words[i]);

    // sequential prefetch, one word every WAIT_CYCLES+2 cycles
    instr_ready = 1'b1;
    fetch_en    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_valid("seq", cyc);
      check_val("seq_latency", 32'(cyc), 32'd3);
      check_val("seq_pc", 32'(instr_pc), 32'h3000 + 32'(i));
      check_val("seq_data", 32'(instr_data), 32'(seq_words[i]));
    end
    fetch_en = 1'b0;
    repeat (3) tick();
    check_val("seq_drained", 32'(fifo_level), 32'd0);
    check_val("seq_busy", 32'(busy), 32'd0);

    // backpressure up to full
    instr_ready = 1'b0;
    fetch_en    = 1'b1;
    n = 0;
    while (fifo_level != 3'd4 && n < 40) begin
      tick();
      n++;
    end
    check_val("bp_fill", 32'(fifo_level), 32'd4);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("bp_full_busy", 32'(busy), 32'd0);
      check_val("bp_full_level", 32'(fifo_level), 32'd4);
    end
    check_head("bp_head", 16'h3004);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check_val("bp_pop_level", 32'(fifo_level), 32'd3);
    check_head("bp_head2", 16'h3005);
    tick();
    check_val("bp_reissue_busy", 32'(busy), 32'd1);
    check_val("bp_reissue_level", 32'(fifo_level), 32'd3);
    n = 0;
    while (fifo_level != 3'd4 && n < 20) begin
      tick();
      n++;
    end
    check_val("bp_refill_cycles", 32'(n), 32'd2);

    // redirect clears FIFO; then redirect again mid-access with two words queued
    do_redirect(16'h3100);
    check_zero_outputs("redir_clear");
    n = 0;
    while (!(fifo_level == 3'd2 && busy) && n < 40) begin
      tick();
      n++;
    end
    check_val("redir_setup_level", 32'(fifo_level), 32'd2);
    check_val("redir_setup_busy", 32'(busy), 32'd1);
    do_redirect(16'h3040);
    check_val("redir_level", 32'(fifo_level), 32'd0);
    check_val("redir_busy", 32'(busy), 32'd0);
    check_val("redir_valid", 32'(instr_valid), 32'd0);
    instr_ready = 1'b1;
    wait_valid("redir_first", cyc);
    check_val("redir_latency", 32'(cyc), 32'd3);
    check_head("redir_w0", 16'h3040);
    wait_valid("redir_second", cyc);
    check_head("redir_w1", 16'h3041);

    // address wrap
    do_redirect(16'hFFFF);
    wait_valid("wrap_a", cyc);
    check_head("wrap_ffff", 16'hFFFF);
    wait_valid("wrap_b", cyc);
    check_head("wrap_0000", 16'h0000);
    fetch_en = 1'b0;
    repeat (3) tick();
    check_val("wrap_drained", 32'(fifo_level), 32'd0);

    // load colliding with completing access returns the old word
    instr_ready = 1'b0;
    fetch_en    = 1'b1;
    do_redirect(16'h3080);
    tick();
    tick();
    check_val("coll_busy", 32'(busy), 32'd1);
    old_word  = mem_m[8'h80];
    load_en   = 1'b1;
    load_addr = 16'h3080;
    load_data = 16'hABCD;
    tick();
    load_en = 1'b0;
    mem_m[8'h80] = 16'hABCD;
    check_val("coll_level", 32'(fifo_level), 32'd1);
    check_val("coll_pc", 32'(instr_pc), 32'h3080);
    check_val("coll_old_data", 32'(instr_data), 32'(old_word));

    // async reset during an access
    tick();
    check_val("rst_pre_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    tick();
    tick();
    reset       = 1'b1;
    instr_ready = 1'b1;
    wait_valid("rst_restart", cyc);
    check_val("rst_restart_latency", 32'(cyc), 32'd3);
    check_head("rst_restart", 16'h3000);
    do_redirect(16'h3080);
    wait_valid("coll_new", cyc);
    check_head("coll_new", 16'h3080);

    // randomized traffic against the in-order scoreboard
    exp_pc = 16'($urandom);
    do_redirect(exp_pc);
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      check_val("rnd_valid_level", 32'(instr_valid), 32'(fifo_level != 3'd0));
      check_val("rnd_level_max", 32'(fifo_level <= 3'd4), 32'd1);
      if (instr_valid) check_head("rnd_head", exp_pc);
      instr_ready = ($urandom_range(0, 2) != 0);
      fetch_en    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 16'($urandom);
        exp_pc         = redirect_pc;
      end else begin
        redirect_valid = 1'b0;
        if (instr_valid && instr_ready) begin
          exp_pc = exp_pc + 16'd1;
          pops++;
        end
      end
      tick();
    end
    redirect_valid = 1'b0;
    check_val("rnd_progress", 32'(pops > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
